// File: rtl/wb_merge_arbiter_pkg.sv
// Shared types and constants for the writeback merge arbiter and its
// round-robin picker.
package wb_merge_arbiter_pkg;

    // Default field widths of one writeback beat
    localparam int WB_WIS_W  = 2;
    localparam int WB_NR_W   = 6;
    localparam int WB_DATA_W = 64;

    // Width of the optional performance counters
    localparam int PERF_W = 44;

    // One writeback beat at the default widths
    typedef struct packed {
        logic [WB_WIS_W-1:0]  wis;
        logic [WB_NR_W-1:0]   rd;
        logic                 eop;
        logic                 tensor;
        logic [WB_DATA_W-1:0] data;
    } wb_beat_t;

    // Packet lock state: IDLE arbitrates freely, LOCKED follows one source
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } wb_lock_state_e;

    // Round-robin index width: clog2 of the source count, at least one bit
    function automatic int rr_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational "first valid request at or after the pointer" picker,
// wrapping modulo N. Produces a onehot grant, its index and an any flag.
module wb_rr_picker
    import wb_merge_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = rr_idx_w(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0] cand;

    // Scan sources starting at ptr and take the first one that is valid
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!any && valid[cand[IDX_W-1:0]]) begin
                any                    = 1'b1;
                grant[cand[IDX_W-1:0]] = 1'b1;
                idx                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_merge_arbiter.sv
// Writeback merge arbiter: merges NUM_SRCS execute-unit result streams into
// one registered writeback stream. Round-robin between packets, locked to one
// source for the duration of a multi-beat packet, no backpressure.
// Optional performance counters are enabled by defining WB_MERGE_PERF_EN.
module wb_merge_arbiter
    import wb_merge_arbiter_pkg::*;
#(
    parameter int NUM_SRCS      = 4,
    parameter int WIS_W         = 2,
    parameter int NR_W          = 6,
    parameter int DATA_W        = 64,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRCS-1:0]        in_valid,
    output logic [NUM_SRCS-1:0]        in_ready,
    input  logic [NUM_SRCS*WIS_W-1:0]  in_wis,
    input  logic [NUM_SRCS*NR_W-1:0]   in_rd,
    input  logic [NUM_SRCS-1:0]        in_eop,
    input  logic [NUM_SRCS-1:0]        in_tensor,
    input  logic [NUM_SRCS*DATA_W-1:0] in_data,
    output logic                       wb_valid,
    output logic [WIS_W-1:0]           wb_wis,
    output logic [NR_W-1:0]            wb_rd,
    output logic                       wb_eop,
    output logic                       wb_tensor,
    output logic [DATA_W-1:0]          wb_data
`ifdef WB_MERGE_PERF_EN
    ,
    output logic [PERF_W-1:0]          perf_wb_beats,
    output logic [PERF_W-1:0]          perf_wb_conflicts,
    output logic [PERF_W-1:0]          perf_wb_lock_stalls
`endif
);

    localparam int IDX_W = rr_idx_w(NUM_SRCS);

    // Same layout as wb_beat_t, sized by this instance's parameters
    typedef struct packed {
        logic [WIS_W-1:0]  wis;
        logic [NR_W-1:0]   rd;
        logic              eop;
        logic              tensor;
        logic [DATA_W-1:0] data;
    } beat_t;

    wb_lock_state_e      state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    lock_idx;
    logic [NUM_SRCS-1:0] pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [NUM_SRCS-1:0] lock_mask;
    logic [IDX_W-1:0]    win_idx;
    logic                granted;
    beat_t               sel_beat;

    wb_rr_picker #(
        .N     (NUM_SRCS),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid (in_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant selection: free round-robin when idle, only the locked source otherwise
    always_comb begin
        lock_mask = NUM_SRCS'(1) << lock_idx;
        if (state == ST_LOCKED) begin
            in_ready = lock_mask & in_valid;
            win_idx  = lock_idx;
            granted  = in_valid[lock_idx];
        end else begin
            in_ready = pick_grant;
            win_idx  = pick_idx;
            granted  = pick_any;
        end
    end

    // Payload mux driven by the onehot grant
    always_comb begin
        sel_beat = '0;
        for (int k = 0; k < NUM_SRCS; k++) begin
            if (in_ready[k]) begin
                sel_beat.wis    = in_wis[k*WIS_W +: WIS_W];
                sel_beat.rd     = in_rd[k*NR_W +: NR_W];
                sel_beat.eop    = in_eop[k];
                sel_beat.tensor = in_tensor[k];
                sel_beat.data   = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Lock FSM, round-robin pointer and registered writeback outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            lock_idx  <= '0;
            wb_valid  <= 1'b0;
            wb_wis    <= '0;
            wb_rd     <= '0;
            wb_eop    <= 1'b0;
            wb_tensor <= 1'b0;
            wb_data   <= '0;
        end else begin
            wb_valid <= granted;
            if (granted) begin
                wb_wis    <= sel_beat.wis;
                wb_rd     <= sel_beat.rd;
                wb_eop    <= sel_beat.eop;
                wb_tensor <= sel_beat.tensor;
                wb_data   <= sel_beat.data;
                if (sel_beat.eop) begin
                    state  <= ST_IDLE;
                    rr_ptr <= (win_idx == IDX_W'(NUM_SRCS-1)) ? '0 : win_idx + IDX_W'(1);
                end else begin
                    state    <= ST_LOCKED;
                    lock_idx <= win_idx;
                end
            end
        end
    end

`ifdef WB_MERGE_PERF_EN
    // Saturating counters for beats, multi-source contention and lock stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_wb_beats       <= '0;
            perf_wb_conflicts   <= '0;
            perf_wb_lock_stalls <= '0;
        end else begin
            if (granted && perf_wb_beats != '1) begin
                perf_wb_beats <= perf_wb_beats + PERF_W'(1);
            end
            if ($countones(in_valid) >= 2 && perf_wb_conflicts != '1) begin
                perf_wb_conflicts <= perf_wb_conflicts + PERF_W'(1);
            end
            if (state == ST_LOCKED && !in_valid[lock_idx] && |(in_valid & ~lock_mask)
                && perf_wb_lock_stalls != '1) begin
                perf_wb_lock_stalls <= perf_wb_lock_stalls + PERF_W'(1);
            end
        end
    end
`endif

`ifndef SYNTHESIS
    logic [31:0]      stall_cnt;
    logic [WIS_W-1:0] pkt_wis;
    logic [NR_W-1:0]  pkt_rd;

    // Track the identity of the open packet and how long the lock has idled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            pkt_wis   <= '0;
            pkt_rd    <= '0;
        end else begin
            if (state == ST_LOCKED && !granted) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= '0;
            end
            if (state == ST_IDLE && granted && !sel_beat.eop) begin
                pkt_wis <= sel_beat.wis;
                pkt_rd  <= sel_beat.rd;
            end
        end
    end

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(in_ready))
        else $error("wb_merge_arbiter: in_ready not onehot0");

    a_pkt_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (state == ST_LOCKED && granted) |-> (sel_beat.wis == pkt_wis && sel_beat.rd == pkt_rd))
        else $error("wb_merge_arbiter: wis/rd changed inside a packet");

    a_lock_timeout : assert property (@(posedge clk) disable iff (!reset_n)
        stall_cnt <= 32'(STALL_TIMEOUT))
        else $error("wb_merge_arbiter: packet lock stalled too long");
`endif

endmodule
